// File: rtl/rr_arb8.sv
// Eight-way round-robin packet arbiter with per-tenure burst limit and no-bubble re-arbitration.
// Optional sticky select/protocol checker enabled by RR_ARB8_ONEHOT_CHECK_EN.
module rr_arb8 #(
  parameter int BURST_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] last,
  input  logic       ready,
  output logic [7:0] sel,
  output logic       out_valid,
  output logic [7:0] ack,
  output logic       sel_err
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e     state_q;
  logic [7:0] sel_q;
  logic [2:0] ptr_q;
  logic [7:0] cnt_q;

  logic [2:0] g;
  logic       req_g;
  logic       xfer;
  logic       tenure_end;
  logic [2:0] ptr_d;
  logic [7:0] pick_d;
  logic [2:0] idx;

  always_comb begin
    g = '0;
    for (int i = 0; i < 8; i++)
      if (sel_q[i]) g = 3'(i);
  end

  assign req_g      = |(req & sel_q);
  assign out_valid  = (state_q == GRANT) && req_g;
  assign xfer       = out_valid && ready;
  assign ack        = xfer ? sel_q : 8'h00;
  assign tenure_end = xfer && ((|(last & sel_q)) || (cnt_q == 8'(BURST_MAX - 1)));
  assign ptr_d      = tenure_end ? g + 3'd1 : ptr_q;
  assign sel        = sel_q;

  // Scan downward so the candidate closest to ptr_d is the last one written.
  always_comb begin
    pick_d = '0;
    idx    = '0;
    for (int i = 7; i >= 0; i--) begin
      idx = ptr_d + 3'(i);
      if (req[idx]) begin
        pick_d      = '0;
        pick_d[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_q <= GRANT;
            sel_q   <= pick_d;
            cnt_q   <= '0;
          end
        end
        GRANT: begin
          if (tenure_end) begin
            ptr_q <= ptr_d;
            cnt_q <= '0;
            if (|req) begin
              sel_q <= pick_d;
            end else begin
              state_q <= IDLE;
              sel_q   <= '0;
            end
          end else if (xfer) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          sel_q   <= '0;
        end
      endcase
    end
  end

`ifdef RR_ARB8_ONEHOT_CHECK_EN
  logic sel_err_q;

  // A granted requester may only drop req after its last beat, which always ends the tenure.
  always_ff @(posedge clk) begin
    if (rst)
      sel_err_q <= 1'b0;
    else if (((sel_q & (sel_q - 8'd1)) != 8'h00) || ((state_q == GRANT) && !req_g))
      sel_err_q <= 1'b1;
  end

  assign sel_err = sel_err_q;
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arb8.sv
// Vector-table bench for rr_arb8 (BURST_MAX=4): each record is one cycle of inputs and the
// outputs expected during that cycle; expectations flow through a scoreboard queue.
module tb_rr_arb8;

`ifdef RR_ARB8_ONEHOT_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] last;
    logic       ready;
    logic [7:0] sel;
    logic       ov;
    logic [7:0] ack;
    logic       err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req, last;
  logic       ready;
  logic [7:0] sel, ack;
  logic       out_valid, sel_err;

  int total = 0;
  int bad   = 0;
  int vnum  = 0;

  vec_t vecs[$];
  vec_t sb[$];

  rr_arb8 #(.BURST_MAX(4)) dut (
    .clk(clk), .rst(rst), .req(req), .last(last), .ready(ready),
    .sel(sel), .out_valid(out_valid), .ack(ack), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic [7:0] rq, logic [7:0] ls, logic rd,
                              logic [7:0] s, logic ov, logic [7:0] a, logic e);
    vec_t v;
    v.rst = r; v.req = rq; v.last = ls; v.ready = rd;
    v.sel = s; v.ov = ov; v.ack = a; v.err = e & CHK;
    return v;
  endfunction

  task automatic check8(string nm, logic [7:0] got, logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL vec%0d %s got=%h exp=%h", vnum, nm, got, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, then compare just after.
  task automatic step(vec_t v);
    vec_t e;
    @(negedge clk);
    rst = v.rst; req = v.req; last = v.last; ready = v.ready;
    sb.push_back(v);
    #1;
    e = sb.pop_front();
    check8("sel", sel, e.sel);
    check8("out_valid", {7'd0, out_valid}, {7'd0, e.ov});
    check8("ack", ack, e.ack);
    check8("sel_err", {7'd0, sel_err}, {7'd0, e.err});
    vnum++;
  endtask

  initial begin
    rst = 1'b1; req = '0; last = '0; ready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state, requests ignored while rst is high
    vecs.push_back(mk(1, 8'hFF, 8'hFF, 1, 8'h00, 0, 8'h00, 0));

    // Back-to-back 0/2 alternation with no idle bubble
    vecs.push_back(mk(0, 8'h05, 8'hFF, 1, 8'h00, 0, 8'h00, 0));
    vecs.push_back(mk(0, 8'h05, 8'hFF, 1, 8'h01, 1, 8'h01, 0));
    vecs.push_back(mk(0, 8'h05, 8'hFF, 1, 8'h04, 1, 8'h04, 0));
    vecs.push_back(mk(0, 8'h05, 8'hFF, 1, 8'h01, 1, 8'h01, 0));
    vecs.push_back(mk(0, 8'h05, 8'hFF, 1, 8'h04, 1, 8'h04, 0));
    vecs.push_back(mk(1, 8'h00, 8'h00, 1, 8'h01, 0, 8'h00, 0));

    // Backpressure on requester 3
    vecs.push_back(mk(0, 8'h08, 8'h08, 0, 8'h00, 0, 8'h00, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 8'h08, 8'h08, 0, 8'h08, 1, 8'h00, 0));
    vecs.push_back(mk(0, 8'h08, 8'h08, 1, 8'h08, 1, 8'h08, 0));
    vecs.push_back(mk(1, 8'h00, 8'h00, 0, 8'h08, 0, 8'h00, 0));

    // Burst limit of 4 on requester 1, then requester 5, then back to 1
    vecs.push_back(mk(0, 8'h22, 8'h00, 1, 8'h00, 0, 8'h00, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 8'h22, 8'h00, 1, 8'h02, 1, 8'h02, 0));
    vecs.push_back(mk(0, 8'h22, 8'h20, 1, 8'h20, 1, 8'h20, 0));
    vecs.push_back(mk(0, 8'h22, 8'h00, 1, 8'h02, 1, 8'h02, 0));
    // req[1] drops mid-packet: grant held, no ack, checker flags it next cycle
    vecs.push_back(mk(0, 8'h20, 8'h00, 1, 8'h02, 0, 8'h00, 0));
    vecs.push_back(mk(0, 8'h20, 8'h00, 1, 8'h02, 0, 8'h00, 1));
    vecs.push_back(mk(0, 8'h22, 8'h02, 1, 8'h02, 1, 8'h02, 1));
    // Reset during beat 3 of requester 5 (ptr was 2): next grant scans from 0
    vecs.push_back(mk(0, 8'h22, 8'h00, 1, 8'h20, 1, 8'h20, 1));
    vecs.push_back(mk(0, 8'h22, 8'h00, 1, 8'h20, 1, 8'h20, 1));
    vecs.push_back(mk(1, 8'h22, 8'h00, 1, 8'h20, 1, 8'h20, 1));
    vecs.push_back(mk(0, 8'h22, 8'h00, 1, 8'h00, 0, 8'h00, 0));
    vecs.push_back(mk(0, 8'h22, 8'h00, 1, 8'h02, 1, 8'h02, 0));
    vecs.push_back(mk(1, 8'h00, 8'h00, 1, 8'h02, 0, 8'h00, 0));

    // Pointer wrap 7 -> 0
    vecs.push_back(mk(0, 8'h80, 8'h80, 1, 8'h00, 0, 8'h00, 0));
    vecs.push_back(mk(0, 8'h81, 8'hFF, 1, 8'h80, 1, 8'h80, 0));
    vecs.push_back(mk(0, 8'h81, 8'hFF, 1, 8'h01, 1, 8'h01, 0));
    vecs.push_back(mk(0, 8'h81, 8'hFF, 1, 8'h80, 1, 8'h80, 0));
    vecs.push_back(mk(1, 8'h00, 8'h00, 1, 8'h01, 0, 8'h00, 0));

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i]);

    // Idle for 10 cycles after reset: nothing granted, nothing acked
    for (int i = 0; i < 10; i++)
      step(mk(0, 8'h00, 8'hFF, 1, 8'h00, 0, 8'h00, 0));

    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard leftover got=%0d exp=0", sb.size());
    end
    total++;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
